mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin burst arbiter sharing one memory port between an
//            I-cache (line fills) and a D-cache (fills and write-backs).
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
   parameter int BURST = 4,
   parameter int AW    = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   // I-cache requester
   input  logic                     i_req,
   input  logic [AW-1:0]            i_addr,
   output logic                     i_rvalid,
   output logic                     i_done,
   // D-cache requester
   input  logic                     d_req,
   input  logic                     d_we,
   input  logic [AW-1:0]            d_addr,
   input  logic [31:0]              d_wdata,
   output logic                     d_wnext,
   output logic                     d_rvalid,
   output logic                     d_done,
   // Shared read data and status
   output logic [31:0]              rdata,
   output logic [$clog2(BURST)-1:0] beat,
   output logic                     busy,
   // Shared memory port
   output logic                     mem_en,
   output logic                     mem_we,
   output logic [AW-1:0]            mem_addr,
   output logic [31:0]              mem_wdata,
   input  logic [31:0]              mem_rdata,
   input  logic                     mem_ready
);

   localparam int            BW        = $clog2(BURST);
   localparam logic [AW-1:0] LINE_MASK = AW'(BURST * 4 - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q;
   logic [BW-1:0]   beat_q;
   logic [AW-1:0]   base_q;
   logic            we_q;
   logic            win_q;      // 1 = D-cache owns the transaction
   logic            last_q;     // 1 = D-cache was granted most recently
   logic            rvalid_q;
   logic [31:0]     rdata_q;

   logic            win_d;
   logic            we_d;
   logic [AW-1:0]   base_d;
   logic            busy_st;
   logic            done_st;

   // On a tie, grant whoever was not served last.
   always_comb begin
      win_d  = d_req & (~i_req | ~last_q);
      we_d   = win_d & d_we;
      base_d = (win_d ? d_addr : i_addr) & ~LINE_MASK;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         beat_q   <= '0;
         base_q   <= '0;
         we_q     <= 1'b0;
         win_q    <= 1'b0;
         last_q   <= 1'b0;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         rvalid_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (i_req || d_req) begin
                  state_q <= S_BUSY;
                  win_q   <= win_d;
                  last_q  <= win_d;
                  we_q    <= we_d;
                  base_q  <= base_d;
                  beat_q  <= '0;
               end
            end
            S_BUSY: begin
               if (mem_ready) begin
                  beat_q <= beat_q + BW'(1);
                  if (!we_q) begin
                     rdata_q  <= mem_rdata;
                     rvalid_q <= 1'b1;
                  end
                  if (beat_q == BW'(BURST - 1)) begin
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy_st = (state_q == S_BUSY);
   assign done_st = (state_q == S_DONE);

   // Memory port is quiet outside BUSY so reset and idle drive all zeros.
   assign mem_en    = busy_st;
   assign mem_we    = busy_st & we_q;
   assign mem_addr  = busy_st ? (base_q | AW'({beat_q, 2'b00})) : '0;
   assign mem_wdata = busy_st ? d_wdata : '0;

   assign d_wnext  = busy_st & we_q & mem_ready;
   assign i_rvalid = rvalid_q & ~win_q;
   assign d_rvalid = rvalid_q & win_q;
   assign i_done   = done_st & ~win_q;
   assign d_done   = done_st & win_q;

   assign rdata = rdata_q;
   assign beat  = beat_q;
   assign busy  = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed vector table plus hand sequences for mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req, d_req, d_we, mem_ready;
   logic [15:0] i_addr, d_addr;
   logic [31:0] d_wdata, mem_rdata;
   logic        i_rvalid, i_done, d_wnext, d_rvalid, d_done, busy;
   logic        mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [31:0] mem_wdata, rdata;
   logic [1:0]  beat;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.BURST(4), .AW(16)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_rvalid(i_rvalid), .i_done(i_done),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_wnext(d_wnext), .d_rvalid(d_rvalid), .d_done(d_done),
      .rdata(rdata), .beat(beat), .busy(busy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   // fl = {i_rvalid, i_done, d_rvalid, d_done, d_wnext}
   typedef struct {
      logic        rst;
      logic        ir;
      logic [15:0] ia;
      logic        dr;
      logic        dwe;
      logic [15:0] da;
      logic [31:0] dwd;
      logic        mr;
      logic [31:0] mrd;
      logic        en;
      logic        we;
      logic [15:0] addr;
      logic [4:0]  fl;
      logic [31:0] rd;
      logic [1:0]  bt;
      logic        bsy;
   } vec_t;

   vec_t v[$];

   task automatic add(input logic r, input logic ir, input logic [15:0] ia,
                      input logic dr, input logic dwe, input logic [15:0] da,
                      input logic [31:0] dwd, input logic mr, input logic [31:0] mrd,
                      input logic en, input logic we, input logic [15:0] a,
                      input logic [4:0] fl, input logic [31:0] rd,
                      input logic [1:0] bt, input logic bs);
      vec_t t;
      t.rst = r;  t.ir = ir; t.ia = ia; t.dr = dr; t.dwe = dwe; t.da = da;
      t.dwd = dwd; t.mr = mr; t.mrd = mrd; t.en = en; t.we = we; t.addr = a;
      t.fl = fl; t.rd = rd; t.bt = bt; t.bsy = bs;
      v.push_back(t);
   endtask

   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", nm, a, e);
      end
   endtask

   logic [89:0] act, expv, msk;
   int          drv_n, leak_n, addr_err;
   logic        got;

   initial begin
      rst = 1'b0; i_req = 0; d_req = 0; d_we = 0; mem_ready = 0;
      i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;

      // Single I-cache read, zero wait states, unaligned request address
      add(1,1,16'h0104,0,0,0,0,1,0,            0,0,0,5'b00000,0,0,0);
      add(1,0,0,0,0,0,32'h1111,1,32'hA0,       1,0,16'h0100,5'b00000,0,0,1);
      add(1,0,0,0,0,0,0,1,32'hA1,              1,0,16'h0104,5'b10000,32'hA0,1,1);
      add(1,0,0,0,0,0,0,1,32'hA2,              1,0,16'h0108,5'b10000,32'hA1,2,1);
      add(1,0,0,0,0,0,0,1,32'hA3,              1,0,16'h010C,5'b10000,32'hA2,3,1);
      add(1,0,0,0,0,0,0,1,0,                   0,0,0,5'b11000,32'hA3,0,1);
      add(1,0,0,0,0,0,0,1,0,                   0,0,0,5'b00000,0,0,0);
      // Reset, then tie: D first, held I next, then D again on the next tie
      add(0,1,16'h0200,1,0,16'h0300,32'hDEAD,1,32'hFF, 0,0,0,5'b00000,0,0,0);
      add(1,1,16'h0200,1,0,16'h0300,0,1,0,     0,0,0,5'b00000,0,0,0);
      add(1,1,16'h0200,0,0,16'h0300,0,1,32'hB0, 1,0,16'h0300,5'b00000,0,0,1);
      add(1,1,16'h0200,0,0,16'h0300,0,1,32'hB1, 1,0,16'h0304,5'b00100,32'hB0,1,1);
      add(1,1,16'h0200,0,0,16'h0300,0,1,32'hB2, 1,0,16'h0308,5'b00100,32'hB1,2,1);
      add(1,1,16'h0200,0,0,16'h0300,0,1,32'hB3, 1,0,16'h030C,5'b00100,32'hB2,3,1);
      add(1,1,16'h0200,0,0,16'h0300,0,1,0,     0,0,0,5'b00110,32'hB3,0,1);
      add(1,1,16'h0200,1,0,16'h0300,0,1,0,     0,0,0,5'b00000,0,0,0);
      add(1,0,0,0,0,0,0,1,32'hC0,              1,0,16'h0200,5'b00000,0,0,1);
      add(1,0,0,0,0,0,0,1,32'hC1,              1,0,16'h0204,5'b10000,32'hC0,1,1);
      add(1,0,0,0,0,0,0,1,32'hC2,              1,0,16'h0208,5'b10000,32'hC1,2,1);
      add(1,0,0,0,0,0,0,1,32'hC3,              1,0,16'h020C,5'b10000,32'hC2,3,1);
      add(1,0,0,0,0,0,0,1,0,                   0,0,0,5'b11000,32'hC3,0,1);
      add(1,1,16'h0200,1,1,16'h8010,0,1,0,     0,0,0,5'b00000,0,0,0);
      // D write-back with mem_ready toggling
      add(1,0,0,0,0,0,32'hD000_0000,1,0,       1,1,16'h8010,5'b00001,0,0,1);
      add(1,0,0,0,0,0,32'hD000_0001,0,0,       1,1,16'h8014,5'b00000,0,1,1);
      add(1,0,0,0,0,0,32'hD000_0001,1,0,       1,1,16'h8014,5'b00001,0,1,1);
      add(1,0,0,0,0,0,32'hD000_0002,0,0,       1,1,16'h8018,5'b00000,0,2,1);
      add(1,0,0,0,0,0,32'hD000_0002,1,0,       1,1,16'h8018,5'b00001,0,2,1);
      add(1,0,0,0,0,0,32'hD000_0003,0,0,       1,1,16'h801C,5'b00000,0,3,1);
      add(1,0,0,0,0,0,32'hD000_0003,1,0,       1,1,16'h801C,5'b00001,0,3,1);
      add(1,0,0,0,0,0,0,1,0,                   0,0,0,5'b00010,0,0,1);
      add(1,0,0,0,0,0,0,1,0,                   0,0,0,5'b00000,0,0,0);
      // Five wait states on beat 2
      add(1,1,16'h0048,0,0,0,0,1,0,            0,0,0,5'b00000,0,0,0);
      add(1,0,0,0,0,0,0,1,32'hE0,              1,0,16'h0040,5'b00000,0,0,1);
      add(1,0,0,0,0,0,0,1,32'hE1,              1,0,16'h0044,5'b10000,32'hE0,1,1);
      add(1,0,0,0,0,0,0,0,32'hEE,              1,0,16'h0048,5'b10000,32'hE1,2,1);
      add(1,0,0,0,0,0,0,0,32'hEE,              1,0,16'h0048,5'b00000,0,2,1);
      add(1,0,0,0,0,0,0,0,32'hEE,              1,0,16'h0048,5'b00000,0,2,1);
      add(1,0,0,0,0,0,0,0,32'hEE,              1,0,16'h0048,5'b00000,0,2,1);
      add(1,0,0,0,0,0,0,0,32'hEE,              1,0,16'h0048,5'b00000,0,2,1);
      add(1,0,0,0,0,0,0,1,32'hE2,              1,0,16'h0048,5'b00000,0,2,1);
      add(1,0,0,0,0,0,0,1,32'hE3,              1,0,16'h004C,5'b10000,32'hE2,3,1);
      add(1,0,0,0,0,0,0,1,0,                   0,0,0,5'b11000,32'hE3,0,1);
      add(1,0,0,0,0,0,0,1,0,                   0,0,0,5'b00000,0,0,0);
      // Reset during beat 1 of a D read with I pending
      add(1,0,0,1,0,16'h1000,0,1,0,            0,0,0,5'b00000,0,0,0);
      add(1,1,16'h2000,0,0,16'h1000,0,1,32'hF0, 1,0,16'h1000,5'b00000,0,0,1);
      add(0,1,16'h2000,0,0,0,32'h5555,1,32'hF1, 0,0,0,5'b00000,0,0,0);
      add(1,1,16'h2000,0,0,0,0,1,0,            0,0,0,5'b00000,0,0,0);
      add(1,0,0,0,0,0,0,1,32'h77,              1,0,16'h2000,5'b00000,0,0,1);

      repeat (2) @(negedge clk);

      for (int k = 0; k < v.size(); k++) begin
         @(negedge clk);
         rst = v[k].rst; i_req = v[k].ir; i_addr = v[k].ia; d_req = v[k].dr;
         d_we = v[k].dwe; d_addr = v[k].da; d_wdata = v[k].dwd;
         mem_ready = v[k].mr; mem_rdata = v[k].mrd;
         #1;
         act  = {mem_en, mem_we, mem_addr, mem_wdata,
                 {i_rvalid, i_done, d_rvalid, d_done, d_wnext}, rdata, beat, busy};
         expv = {v[k].en, v[k].we, v[k].addr, (v[k].en ? v[k].dwd : 32'h0),
                 v[k].fl, v[k].rd, v[k].bt, v[k].bsy};
         msk  = '1;
         if (v[k].rst) begin
            if (!v[k].en) begin
               msk[88]    = 1'b0;
               msk[87:40] = '0;
               msk[2:1]   = '0;
            end
            if (!(v[k].fl[4] || v[k].fl[2])) msk[34:3] = '0;
         end
         total++;
         if ((act & msk) !== (expv & msk)) begin
            bad++;
            $display("FAIL row%0d act=%h exp=%h", k, act & msk, expv & msk);
         end
      end

      // Reset asserted off-edge in the middle of an I read
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("async_rst", {19'd0, mem_en, busy, i_rvalid, i_done, d_rvalid, d_done, beat, mem_addr[3:0]}, 32'h0);
      chk("async_rst_addr", {16'd0, mem_addr}, 32'h0);
      chk("async_rst_rdata", rdata, 32'h0);

      // D read with random wait states; bounded wait for completion
      @(negedge clk);
      rst = 1'b1; i_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h3008; mem_ready = 1'b1;
      drv_n = 0; leak_n = 0; addr_err = 0; got = 1'b0;
      for (int c = 0; c < 60 && !got; c++) begin
         @(negedge clk);
         d_req = 1'b0;
         mem_ready = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         #1;
         if (d_rvalid) drv_n++;
         if (i_rvalid || i_done || d_wnext) leak_n++;
         if (mem_en && mem_addr[15:4] != 12'h300) addr_err++;
         if (d_done) got = 1'b1;
      end
      chk("rand_done", {31'd0, got}, 32'd1);
      chk("rand_rvalid_cnt", drv_n, 32'd4);
      chk("rand_i_leak", leak_n, 32'd0);
      chk("rand_addr_line", addr_err, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
